// File: rtl/conv2d_engine.sv
// conv2d_engine: on-chip image/filter buffers feeding one signed MAC per cycle,
// streaming 2D convolution results filter-major over a valid/ready port.
module conv2d_engine #(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int K           = 2,
    parameter int NUM_FILTERS = 4,
    parameter int STRIDE      = 1,
    parameter int RELU        = 0,
    parameter int ACC_W       = 2*DATA_W+$clog2(K*K)+1,
    parameter int ADDR_W      = $clog2((IMG_W*IMG_H > NUM_FILTERS*K*K) ?
                                       IMG_W*IMG_H : NUM_FILTERS*K*K),
    localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_en,
    input  logic                    ld_sel,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [DATA_W-1:0]       ld_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_data,
    output logic [FW-1:0]           res_filter,
    output logic [RW-1:0]           res_row,
    output logic [CW-1:0]           res_col,
    output logic                    done
);

    localparam int OUT_W = (IMG_W-K)/STRIDE+1;
    localparam int OUT_H = (IMG_H-K)/STRIDE+1;
    localparam int IMG_N = IMG_W*IMG_H;
    localparam int FLT_N = NUM_FILTERS*K*K;
    localparam int IA_W  = (IMG_N > 1) ? $clog2(IMG_N) : 1;
    localparam int FA_W  = (FLT_N > 1) ? $clog2(FLT_N) : 1;
    localparam int TW    = (K > 1) ? $clog2(K) : 1;
    localparam int PW    = 2*DATA_W;

    localparam logic [TW-1:0] T_LAST = TW'(K-1);
    localparam logic [CW-1:0] C_LAST = CW'(OUT_W-1);
    localparam logic [RW-1:0] R_LAST = RW'(OUT_H-1);
    localparam logic [FW-1:0] F_LAST = FW'(NUM_FILTERS-1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;
    state_t state, state_nx;

    logic signed [DATA_W-1:0] img_mem [IMG_N];
    logic signed [DATA_W-1:0] flt_mem [FLT_N];

    logic [TW-1:0]           ti, tj;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [FW-1:0]           fil;
    logic signed [ACC_W-1:0] acc;
    logic [IA_W-1:0]         img_ra;
    logic [FA_W-1:0]         flt_ra;
    logic signed [PW-1:0]    pix, wgt, prod;
    logic                    last_tap, last_res;

    // Memories are intentionally not reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (ld_en && state == S_IDLE) begin
            if (!ld_sel && int'(ld_addr) < IMG_N)
                img_mem[ld_addr[IA_W-1:0]] <= $signed(ld_data);
            if (ld_sel && int'(ld_addr) < FLT_N)
                flt_mem[ld_addr[FA_W-1:0]] <= $signed(ld_data);
        end
    end

    assign img_ra = IA_W'((int'(row)*STRIDE + int'(ti))*IMG_W
                          + int'(col)*STRIDE + int'(tj));
    assign flt_ra = FA_W'((int'(fil)*K + int'(ti))*K + int'(tj));

    assign pix  = PW'(img_mem[img_ra]);
    assign wgt  = PW'(flt_mem[flt_ra]);
    assign prod = pix * wgt;

    assign last_tap = (ti == T_LAST) && (tj == T_LAST);
    assign last_res = (col == C_LAST) && (row == R_LAST) && (fil == F_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nx = S_MAC;
            S_MAC: begin
                busy = 1'b1;
                if (last_tap) state_nx = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_nx = last_res ? S_DONE : S_MAC;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ti  <= '0;
            tj  <= '0;
            col <= '0;
            row <= '0;
            fil <= '0;
            acc <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    ti  <= '0;
                    tj  <= '0;
                    col <= '0;
                    row <= '0;
                    fil <= '0;
                    acc <= '0;
                end
                S_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (tj == T_LAST) begin
                        tj <= '0;
                        ti <= (ti == T_LAST) ? '0 : ti + 1'b1;
                    end else begin
                        tj <= tj + 1'b1;
                    end
                end
                S_EMIT: if (res_ready) begin
                    acc <= '0;
                    // col fastest, then row, then filter; all wrap to 0 at the end
                    if (col == C_LAST) begin
                        col <= '0;
                        if (row == R_LAST) begin
                            row <= '0;
                            fil <= (fil == F_LAST) ? '0 : fil + 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_data   = !res_valid ? '0 :
                        (RELU != 0 && acc[ACC_W-1]) ? '0 : acc;
    assign res_filter = fil;
    assign res_row    = row;
    assign res_col    = col;

endmodule

// File: tb/tb_conv2d_engine.sv
// Directed bench: three engine instances (stride 1, stride 2, ReLU) on a 4x4
// image with two 2x2 filters, checked against hand-derived result tables.
module tb_conv2d_engine;

    localparam int LIM = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ld_en = 1'b0;
    logic             ld_sel = 1'b0;
    logic [3:0]       ld_addr = '0;
    logic [7:0]       ld_data = '0;
    logic [2:0]       start_v = '0;
    logic             res_ready = 1'b1;
    logic [2:0]       busy_v, valid_v, done_v;
    logic [2:0][18:0] data_p;
    logic [2:0][0:0]  fil_p;
    logic [2:0][1:0]  row_p, col_p;

    typedef struct {
        int f;
        int r;
        int c;
        int d;
    } res_t;

    res_t q0[$], q1[$], q2[$];
    int   done_cnt [3] = '{0, 0, 0};
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    conv2d_engine #(.IMG_W(4), .IMG_H(4), .K(2), .NUM_FILTERS(2),
                    .STRIDE(1), .RELU(0)) u_s1 (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start_v[0]),
        .busy(busy_v[0]), .res_valid(valid_v[0]), .res_ready(res_ready),
        .res_data(data_p[0]), .res_filter(fil_p[0]), .res_row(row_p[0]),
        .res_col(col_p[0]), .done(done_v[0]));

    conv2d_engine #(.IMG_W(4), .IMG_H(4), .K(2), .NUM_FILTERS(2),
                    .STRIDE(2), .RELU(0)) u_s2 (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start_v[1]),
        .busy(busy_v[1]), .res_valid(valid_v[1]), .res_ready(res_ready),
        .res_data(data_p[1]), .res_filter(fil_p[1]), .res_row(row_p[1]),
        .res_col(col_p[1]), .done(done_v[1]));

    conv2d_engine #(.IMG_W(4), .IMG_H(4), .K(2), .NUM_FILTERS(2),
                    .STRIDE(1), .RELU(1)) u_rl (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start_v[2]),
        .busy(busy_v[2]), .res_valid(valid_v[2]), .res_ready(res_ready),
        .res_data(data_p[2]), .res_filter(fil_p[2]), .res_row(row_p[2]),
        .res_col(col_p[2]), .done(done_v[2]));

    function automatic res_t mk(input int d);
        res_t r;
        r.f = int'(fil_p[d]);
        r.r = int'(row_p[d]);
        r.c = int'(col_p[d]);
        r.d = int'($signed(data_p[d]));
        return r;
    endfunction

    function automatic logic [23:0] outs(input int d);
        return {fil_p[d], row_p[d], col_p[d], data_p[d]};
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic res_t qget(input int d, input int i);
        case (d)
            0:       return q0[i];
            1:       return q1[i];
            default: return q2[i];
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (done_v[i]) done_cnt[i]++;
        if (valid_v[0] && res_ready) q0.push_back(mk(0));
        if (valid_v[1] && res_ready) q1.push_back(mk(1));
        if (valid_v[2] && res_ready) q2.push_back(mk(2));
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic sel, input int a, input int v);
        @(posedge clk);
        #1;
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = 4'(a);
        ld_data = 8'(v);
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic load_all(input bit ext);
        int f1 [4] = '{1, 0, 0, -1};
        for (int i = 0; i < 16; i++) load(1'b0, i, ext ? -128 : i);
        for (int i = 0; i < 4; i++) load(1'b1, i, ext ? -128 : 1);
        for (int i = 0; i < 4; i++) load(1'b1, 4 + i, ext ? -128 : f1[i]);
    endtask

    // mode 0: ready high, 1: random ready, 2: stall third result, 3: poke busy
    task automatic run_pass(input int d, input int mode, output int base,
                            output int dbase, output int lat, output int ncyc);
        bit          held;
        bit          stable;
        logic [23:0] snap;
        int          n;
        held = 0;
        lat  = -1;
        @(posedge clk);
        #1;
        res_ready  = 1'b1;
        base       = qsize(d);
        dbase      = done_cnt[d];
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        for (n = 0; n < LIM; n++) begin
            @(negedge clk);
            if (lat < 0 && valid_v[d]) lat = n + 1;
            if (done_v[d]) break;
            if (mode == 2 && !held && !res_ready && valid_v[d]) begin
                snap   = outs(d);
                stable = 1;
                repeat (20) begin
                    @(negedge clk);
                    if (!valid_v[d] || outs(d) !== snap) stable = 0;
                end
                check("bp_stable", 32'(stable), 1);
                check("bp_no_skip", qsize(d) - base, 2);
                held = 1;
            end
            @(posedge clk);
            #1;
            case (mode)
                1: res_ready = 1'($urandom_range(0, 1));
                2: res_ready = held || (qsize(d) - base != 2);
                3: begin
                    ld_en      = (n == 3);
                    ld_sel     = 1'b0;
                    ld_addr    = '0;
                    ld_data    = 8'd99;
                    start_v[d] = (n == 3);
                end
                default: res_ready = 1'b1;
            endcase
        end
        ncyc = n;
        check("pass_done", 32'(n < LIM), 1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        ld_en     = 1'b0;
    endtask

    // kind 0: stride 1, 1: stride 2, 2: ReLU, 3: all -128
    task automatic verify(input int d, input int kind, input int base,
                          input int dbase);
        int   no;
        int   idx;
        int   e;
        res_t r;
        no  = (kind == 1) ? 2 : 3;
        check($sformatf("d%0d count", d), qsize(d) - base, 2*no*no);
        check($sformatf("d%0d done_pulses", d), done_cnt[d] - dbase, 1);
        idx = base;
        for (int f = 0; f < 2; f++)
            for (int rr = 0; rr < no; rr++)
                for (int cc = 0; cc < no; cc++) begin
                    case (kind)
                        0:       e = (f == 0) ? 16*rr + 4*cc + 10 : -5;
                        1:       e = (f == 0) ? 32*rr + 8*cc + 10 : -5;
                        2:       e = (f == 0) ? 16*rr + 4*cc + 10 : 0;
                        default: e = 65536;
                    endcase
                    if (idx < qsize(d)) begin
                        r = qget(d, idx);
                        check($sformatf("d%0d #%0d pos", d, idx - base),
                              r.f*100 + r.r*10 + r.c, f*100 + rr*10 + cc);
                        check($sformatf("d%0d f%0d r%0d c%0d data", d, f, rr, cc),
                              r.d, e);
                    end
                    idx++;
                end
    endtask

    initial begin
        int b, db, lat, nc;
        #2;
        check("rst_busy", 32'(busy_v[0]), 0);
        check("rst_valid", 32'(valid_v[0]), 0);
        check("rst_done", 32'(done_v[0]), 0);
        check("rst_data", 32'(data_p[0]), 0);
        check("rst_filter", 32'(fil_p[0]), 0);
        check("rst_row", 32'(row_p[0]), 0);
        check("rst_col", 32'(col_p[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        load_all(1'b0);
        load(1'b1, 9, 50);

        run_pass(1, 0, b, db, lat, nc);
        verify(1, 1, b, db);
        check("s2_pass_cycles", nc, 40);

        run_pass(2, 0, b, db, lat, nc);
        verify(2, 2, b, db);

        run_pass(0, 0, b, db, lat, nc);
        verify(0, 0, b, db);
        check("latency", lat, 5);
        check("s1_pass_cycles", nc, 90);

        run_pass(0, 2, b, db, lat, nc);
        verify(0, 0, b, db);

        run_pass(0, 1, b, db, lat, nc);
        verify(0, 0, b, db);

        run_pass(0, 3, b, db, lat, nc);
        verify(0, 0, b, db);
        repeat (10) @(posedge clk);
        #1;
        check("no_restart_busy", 32'(busy_v[0]), 0);
        check("no_restart_done", done_cnt[0] - db, 1);

        run_pass(0, 0, b, db, lat, nc);
        verify(0, 0, b, db);

        @(posedge clk);
        #1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_abort_busy", 32'(busy_v[0]), 1);
        db = done_cnt[0];
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_v[0]), 0);
        check("abort_valid", 32'(valid_v[0]), 0);
        check("abort_data", 32'(data_p[0]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt[0] - db, 0);
        check("abort_idle", 32'(busy_v[0]), 0);

        run_pass(0, 0, b, db, lat, nc);
        verify(0, 0, b, db);

        load_all(1'b1);
        run_pass(0, 0, b, db, lat, nc);
        verify(0, 3, b, db);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
